// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arbiter_pkg;

  localparam int unsigned QW_DEFAULT = 4;

  typedef enum logic {
    WRR_IDLE  = 1'b0,
    WRR_GRANT = 1'b1
  } wrr_state_e;

  // Width of a port index; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating-priority encoder: first requesting port at or after i_start, wrapping.
module rr_pick #(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = 3
) (
  input  logic [N-1:0]  i_request,
  input  logic [SW-1:0] i_start,
  input  logic          i_mask_en,
  output logic          o_found,
  output logic [SW-1:0] o_index
);

  logic [N-1:0] w_req;

  // The mask clears the port just before the start point (the port being released).
  always_comb begin
    w_req = i_request;
    if (i_mask_en) begin
      w_req[SW'((int'(i_start) + int'(N) - 1) % int'(N))] = 1'b0;
    end
  end

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (w_req[SW'((int'(i_start) + i) % int'(N))]) begin
        o_found = 1'b1;
        o_index = SW'((int'(i_start) + i) % int'(N));
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with per-port burst quantum and zero-bubble handoff.
// Optional feature: define WRR_ARBITER_LOCK_EN to let lock[] extend a grant past its quantum.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 8,
  parameter int unsigned QW        = QW_DEFAULT,
  parameter int unsigned SEL_WIDTH = sel_width(NUM_PORTS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_PORTS-1:0]    request,
  input  logic [NUM_PORTS*QW-1:0] quantum,
  input  logic [NUM_PORTS-1:0]    lock,
  input  logic                    accept,
  output logic [NUM_PORTS-1:0]    grant,
  output logic [SEL_WIDTH-1:0]    select,
  output logic                    active,
  output logic [QW-1:0]           credit
);

  wrr_state_e             r_state, w_state_nxt;
  logic [SEL_WIDTH-1:0]   r_ptr, w_ptr_nxt;
  logic [SEL_WIDTH-1:0]   r_sel, w_sel_nxt;
  logic [NUM_PORTS-1:0]   r_grant, w_grant_nxt;
  logic [QW-1:0]          r_credit, w_credit_nxt;
  logic                   r_active, w_active_nxt;

  logic [QW-1:0]          w_quanta [NUM_PORTS];
  logic [QW-1:0]          w_fresh_credit;
  logic [SEL_WIDTH-1:0]   w_next_port;
  logic [SEL_WIDTH-1:0]   w_pick_start;
  logic [SEL_WIDTH-1:0]   w_pick_idx;
  logic                   w_pick_found;
  logic                   w_locked;
  logic                   w_rel_drop;
  logic                   w_rel_spent;
  logic                   w_release;

  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      w_quanta[i] = quantum[i*int'(QW) +: QW];
    end
  end

  // A zero quantum still buys one beat.
  assign w_fresh_credit = (w_quanta[w_pick_idx] == '0) ? QW'(1) : w_quanta[w_pick_idx];

`ifdef WRR_ARBITER_LOCK_EN
  assign w_locked = lock[r_sel] & request[r_sel];
`else
  logic w_lock_unused;
  assign w_lock_unused = ^lock;
  assign w_locked      = 1'b0;
`endif

  assign w_rel_drop  = (r_state == WRR_GRANT) && !request[r_sel];
  assign w_rel_spent = (r_state == WRR_GRANT) && accept && (r_credit == QW'(1)) && !w_locked;
  assign w_release   = w_rel_drop || w_rel_spent;

  assign w_next_port  = (r_sel == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : r_sel + SEL_WIDTH'(1);
  assign w_pick_start = (r_state == WRR_IDLE) ? r_ptr : w_next_port;

  rr_pick #(
    .N  (NUM_PORTS),
    .SW (SEL_WIDTH)
  ) u_pick (
    .i_request (request),
    .i_start   (w_pick_start),
    .i_mask_en (w_rel_drop),
    .o_found   (w_pick_found),
    .o_index   (w_pick_idx)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_sel_nxt    = r_sel;
    w_grant_nxt  = r_grant;
    w_credit_nxt = r_credit;
    w_active_nxt = r_active;
    case (r_state)
      WRR_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt  = WRR_GRANT;
          w_sel_nxt    = w_pick_idx;
          w_grant_nxt  = NUM_PORTS'(1) << w_pick_idx;
          w_credit_nxt = w_fresh_credit;
          w_active_nxt = 1'b1;
        end
      end
      WRR_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_next_port;
          if (w_pick_found) begin
            w_sel_nxt    = w_pick_idx;
            w_grant_nxt  = NUM_PORTS'(1) << w_pick_idx;
            w_credit_nxt = w_fresh_credit;
          end else begin
            w_state_nxt  = WRR_IDLE;
            w_sel_nxt    = '0;
            w_grant_nxt  = '0;
            w_credit_nxt = '0;
            w_active_nxt = 1'b0;
          end
        end else if (accept && (r_credit > QW'(1))) begin
          // A locked grant parks at credit 1 instead of releasing.
          w_credit_nxt = r_credit - QW'(1);
        end
      end
      default: begin
        w_state_nxt = WRR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= WRR_IDLE;
      r_ptr    <= '0;
      r_sel    <= '0;
      r_grant  <= '0;
      r_credit <= '0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_sel    <= w_sel_nxt;
      r_grant  <= w_grant_nxt;
      r_credit <= w_credit_nxt;
      r_active <= w_active_nxt;
    end
  end

  assign grant  = r_grant;
  assign select = r_sel;
  assign active = r_active;
  assign credit = r_credit;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_wrr_arbiter;

  localparam int N  = 8;
  localparam int QW = 4;

  logic          clk;
  logic          rstn;
  logic [N-1:0]  request;
  logic [N*QW-1:0] quantum;
  logic [N-1:0]  lock;
  logic          accept;
  logic [N-1:0]  grant;
  logic [2:0]    select;
  logic          active;
  logic [QW-1:0] credit;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_active, m_sel, m_credit, m_ptr;

  wrr_arbiter #(.NUM_PORTS(N), .QW(QW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .request (request),
    .quantum (quantum),
    .lock    (lock),
    .accept  (accept),
    .grant   (grant),
    .select  (select),
    .active  (active),
    .credit  (credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int q_of(input int p);
    int v;
    v = int'(quantum[p*QW +: QW]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int search(input int start, input logic [N-1:0] r);
    for (int off = 0; off < N; off++) begin
      if (r[(start + off) % N]) return (start + off) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_sel = 0; m_credit = 0; m_ptr = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int w;
    logic [N-1:0] r;
    bit drop, last, hold;
    r = request;
    if (m_active == 0) begin
      w = search(m_ptr, r);
      if (w >= 0) begin
        m_active = 1; m_sel = w; m_credit = q_of(w);
      end
    end else begin
      drop = !r[m_sel];
      hold = 1'b0;
`ifdef WRR_ARBITER_LOCK_EN
      hold = lock[m_sel] && r[m_sel];
`endif
      last = accept && (m_credit == 1) && !hold;
      if (drop || last) begin
        m_ptr = (m_sel + 1) % N;
        if (drop) r[m_sel] = 1'b0;
        w = search(m_ptr, r);
        if (w >= 0) begin
          m_sel = w; m_credit = q_of(w);
        end else begin
          m_active = 0; m_sel = 0; m_credit = 0;
        end
      end else if (accept && m_credit > 1) begin
        m_credit--;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = (m_active != 0) ? (N'(1) << m_sel) : '0;
    chk({tag, ".grant"},  32'(grant),  32'(eg));
    chk({tag, ".select"}, 32'(select), 32'(m_sel));
    chk({tag, ".active"}, 32'(active), 32'(m_active));
    chk({tag, ".credit"}, 32'(credit), 32'(m_credit));
  endtask

  task automatic drive(input string tag, input logic [N-1:0] req, input logic acc);
    request = req;
    accept  = acc;
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rstn = 1'b0; request = '0; accept = 1'b0; lock = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rstn = 1'b1;
  endtask

  initial begin
    int rot_exp [6];
    int wsel [6];
    int wcr [6];
    rot_exp = '{0, 1, 3, 0, 1, 3};
    wsel    = '{2, 2, 2, 5, 2, 2};
    wcr     = '{3, 2, 1, 1, 3, 2};
    quantum = '0;
    do_reset();

    // Asynchronous reset in the middle of a grant
    quantum = 32'h22222222;
    repeat (3) drive("pre_rst", 8'hFF, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst.grant",  32'(grant),  32'h0);
    chk("async_rst.select", 32'(select), 32'h0);
    chk("async_rst.active", 32'(active), 32'h0);
    chk("async_rst.credit", 32'(credit), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    quantum = 32'h22222223;
    drive("post_rst", 8'h05, 1'b0);
    chk("post_rst.grant",  32'(grant),  32'h01);
    chk("post_rst.credit", 32'(credit), 32'd3);

    // Rotation with unit quanta
    do_reset();
    quantum = 32'h11111111;
    for (int k = 0; k < 6; k++) begin
      drive("rot", 8'h0B, 1'b1);
      chk("rot.sel", 32'(select), 32'(rot_exp[k]));
      chk("rot.active", 32'(active), 32'd1);
    end

    // Weighting: port 2 gets 3 beats, port 5 gets 1
    do_reset();
    quantum = 32'h00100300;
    for (int k = 0; k < 6; k++) begin
      drive("wgt", 8'h24, 1'b1);
      chk("wgt.sel", 32'(select), 32'(wsel[k]));
      chk("wgt.credit", 32'(credit), 32'(wcr[k]));
    end

    // Stall holds the grant, then an early drop goes idle and moves the pointer past port 4
    do_reset();
    quantum = 32'h00050000;
    drive("stall0", 8'h10, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive("stall", 8'h10, 1'b0);
      chk("stall.grant", 32'(grant), 32'h10);
      chk("stall.credit", 32'(credit), 32'd5);
    end
    drive("drop", 8'h00, 1'b0);
    chk("drop.active", 32'(active), 32'd0);
    drive("ptr5", 8'h41, 1'b0);
    chk("ptr5.sel", 32'(select), 32'd6);

    // Zero quantum behaves as one
    do_reset();
    quantum = '0;
    drive("q0a", 8'h08, 1'b1);
    chk("q0a.credit", 32'(credit), 32'd1);
    drive("q0b", 8'h08, 1'b1);
    chk("q0b.credit", 32'(credit), 32'd1);

    // Sole requester regrants back-to-back, then the search wraps 7 -> 0
    do_reset();
    quantum = 32'h20000000;
    for (int k = 0; k < 4; k++) begin
      drive("sole", 8'h80, 1'b1);
      chk("sole.sel", 32'(select), 32'd7);
      chk("sole.credit", 32'(credit), (k % 2 == 0) ? 32'd2 : 32'd1);
    end
    drive("wrap", 8'h81, 1'b1);
    chk("wrap.sel", 32'(select), 32'd0);

`ifdef WRR_ARBITER_LOCK_EN
    // Lock extends port 1 beyond its quantum; release on first accept after unlock
    do_reset();
    quantum = 32'h00000020;
    lock = 8'h02;
    drive("lk0", 8'h0A, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive("lk", 8'h0A, 1'b1);
      chk("lk.sel", 32'(select), 32'd1);
      chk("lk.credit", 32'(credit), 32'd1);
    end
    lock = 8'h00;
    drive("unlk", 8'h0A, 1'b0);
    chk("unlk.sel", 32'(select), 32'd1);
    drive("unlk_rel", 8'h0A, 1'b1);
    chk("unlk_rel.sel", 32'(select), 32'd3);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] rq;
      quantum = $urandom;
      lock    = N'($urandom) & N'($urandom);
      rq      = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 9) == 0) rq = '0;
      if ($urandom_range(0, 499) == 0) do_reset();
      drive("rand", rq, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
